// File: rtl/decode_pkg.sv
// Shared field layout for the dual-issue decode interface.
// Used by the pair encoder and by the decoder-side bench.
package decode_pkg;

    localparam int OP_W    = 4;
    localparam int REG_W   = 4;
    localparam int IME_W   = 5;
    localparam int INSTR_W = 32;

    localparam int OP_LSB  = 28;
    localparam int DES_LSB = 24;
    localparam int S1_LSB  = 20;
    localparam int S2_LSB  = 16;
    localparam int IME_LSB = 0;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] des;
        logic [REG_W-1:0] s1;
        logic [REG_W-1:0] s2;
        logic [IME_W-1:0] ime;
    } instr_fields_t;

    // Bits [15:5] are reserved and always encode as zero.
    function automatic logic [INSTR_W-1:0] encode_instr(input instr_fields_t f);
        logic [INSTR_W-1:0] word;
        word = '0;
        word[OP_LSB  +: OP_W]  = f.op;
        word[DES_LSB +: REG_W] = f.des;
        word[S1_LSB  +: REG_W] = f.s1;
        word[S2_LSB  +: REG_W] = f.s2;
        word[IME_LSB +: IME_W] = f.ime;
        return word;
    endfunction

endpackage

// File: rtl/instr_pair_fifo.sv
// Synchronous FIFO holding instruction pairs; head is shown combinationally
// and reads as zero whenever the FIFO is empty.
module instr_pair_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    // Storage needs no reset: stale entries are never visible past the count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instr_pair_encoder.sv
// Packs single instructions into 32-bit words, pairs them (older in slot 1)
// and queues the pairs for the decode stage.
module instr_pair_encoder
    import decode_pkg::*;
#(
    parameter int         DEPTH  = 4,
    parameter logic [3:0] NOP_OP = 4'h0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_op,
    input  logic [3:0]             in_des,
    input  logic [3:0]             in_s1,
    input  logic [3:0]             in_s2,
    input  logic [4:0]             in_ime,
    input  logic                   flush,
    output logic [31:0]            new_instr1_in,
    output logic [31:0]            new_instr2_in,
    output logic                   pair_valid,
    input  logic                   pair_ready,
    output logic                   half_pending,
    output logic [$clog2(DEPTH):0] count
);

    localparam logic [INSTR_W-1:0] NOP_INSTR = {NOP_OP, {(INSTR_W-OP_W){1'b0}}};

    instr_fields_t        fields;
    logic [INSTR_W-1:0]   encoded;
    logic [INSTR_W-1:0]   staged;
    logic [2*INSTR_W-1:0] push_pair;
    logic [2*INSTR_W-1:0] head_pair;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;

    always_comb begin
        fields     = '0;
        fields.op  = in_op;
        fields.des = in_des;
        fields.s1  = in_s1;
        fields.s2  = in_s2;
        fields.ime = in_ime;
        encoded    = encode_instr(fields);
    end

    // Staging a first half never pushes, so it stays legal even when full.
    assign in_ready   = !full || (!half_pending && !flush);
    assign accept     = in_valid && in_ready;
    assign pair_valid = !empty;
    assign pop        = pair_valid && pair_ready;

    always_comb begin
        push      = 1'b0;
        push_pair = {staged, NOP_INSTR};
        if (accept && half_pending) begin
            push      = 1'b1;
            push_pair = {staged, encoded};
        end else if (accept && flush) begin
            push      = 1'b1;
            push_pair = {encoded, NOP_INSTR};
        end else if (!accept && flush && half_pending && !full) begin
            push      = 1'b1;
            push_pair = {staged, NOP_INSTR};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            staged       <= '0;
            half_pending <= 1'b0;
        end else if (accept && !half_pending && !flush) begin
            staged       <= encoded;
            half_pending <= 1'b1;
        end else if (push && half_pending) begin
            half_pending <= 1'b0;
        end
    end

    instr_pair_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (push_pair),
        .dout  (head_pair),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign new_instr1_in = head_pair[2*INSTR_W-1:INSTR_W];
    assign new_instr2_in = head_pair[INSTR_W-1:0];

endmodule

// File: tb/tb_instr_pair_encoder.sv
// Directed bench for instr_pair_encoder: pairing, flush padding, full-FIFO
// back-pressure, order across pointer wrap and mid-operation reset.
module tb_instr_pair_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [3:0]  in_des;
    logic [3:0]  in_s1;
    logic [3:0]  in_s2;
    logic [4:0]  in_ime;
    logic        flush;
    logic [31:0] new_instr1_in;
    logic [31:0] new_instr2_in;
    logic        pair_valid;
    logic        pair_ready;
    logic        half_pending;
    logic [2:0]  count;

    int passed = 0;
    int total  = 0;

    instr_pair_encoder #(.DEPTH(4), .NOP_OP(4'h0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_des        (in_des),
        .in_s1         (in_s1),
        .in_s2         (in_s2),
        .in_ime        (in_ime),
        .flush         (flush),
        .new_instr1_in (new_instr1_in),
        .new_instr2_in (new_instr2_in),
        .pair_valid    (pair_valid),
        .pair_ready    (pair_ready),
        .half_pending  (half_pending),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected word for indexed instruction i, built straight from the field layout.
    function automatic logic [31:0] word_of(input int i);
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [4:0] e;
        a = 4'(i);
        b = 4'(15 - i);
        c = 4'(i + 1);
        e = 5'(i);
        return {a, b, a, c, 11'h000, e};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [3:0] des,
                                 input logic [3:0] s1, input logic [3:0] s2, input logic [4:0] ime,
                                 input logic fl, input logic pr);
        in_valid   = v;
        in_op      = op;
        in_des     = des;
        in_s1      = s1;
        in_s2      = s2;
        in_ime     = ime;
        flush      = fl;
        pair_ready = pr;
    endtask

    task automatic applyIndex(input logic v, input int i, input logic fl, input logic pr);
        applyStimulus(v, 4'(i), 4'(15 - i), 4'(i), 4'(i + 1), 5'(i), fl, pr);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 5'h0, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset state
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_pair_valid", 32'(pair_valid), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_half_pending", 32'(half_pending), 32'd0);
        checkOutput("rst_instr1", new_instr1_in, 32'h0);
        checkOutput("rst_instr2", new_instr2_in, 32'h0);

        // Simple pair, consumed as soon as it appears
        applyStimulus(1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 5'd5, 1'b0, 1'b1);
        step();
        checkOutput("pair_half_pending", 32'(half_pending), 32'd1);
        checkOutput("pair_not_yet_valid", 32'(pair_valid), 32'd0);
        applyStimulus(1'b1, 4'h6, 4'h7, 4'h8, 4'h9, 5'd31, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 5'h0, 1'b0, 1'b1);
        checkOutput("pair_valid", 32'(pair_valid), 32'd1);
        checkOutput("pair_instr1", new_instr1_in, 32'h1234_0005);
        checkOutput("pair_instr2", new_instr2_in, 32'h6789_001F);
        checkOutput("pair_half_cleared", 32'(half_pending), 32'd0);
        step();
        checkOutput("pair_popped_count", 32'(count), 32'd0);

        // Flush pads a lone instruction with NOP
        applyStimulus(1'b1, 4'hA, 4'hB, 4'hC, 4'hD, 5'd3, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 5'h0, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 5'h0, 1'b0, 1'b1);
        checkOutput("flush_half_pending", 32'(half_pending), 32'd0);
        checkOutput("flush_count", 32'(count), 32'd1);
        checkOutput("flush_instr1", new_instr1_in, 32'hABCD_0003);
        checkOutput("flush_instr2", new_instr2_in, 32'h0000_0000);
        step();
        checkOutput("flush_drained", 32'(count), 32'd0);

        // Fill the FIFO, then stage one more while full
        for (int i = 0; i < 8; i++) begin
            applyIndex(1'b1, i, 1'b0, 1'b0);
            step();
        end
        checkOutput("full_count", 32'(count), 32'd4);
        checkOutput("full_in_ready", 32'(in_ready), 32'd1);
        applyIndex(1'b1, 8, 1'b0, 1'b0);
        step();
        checkOutput("full_staged_half", 32'(half_pending), 32'd1);
        checkOutput("full_in_ready_low", 32'(in_ready), 32'd0);
        applyIndex(1'b1, 9, 1'b0, 1'b1);
        step();
        checkOutput("full_pop_count", 32'(count), 32'd3);
        checkOutput("full_in_ready_back", 32'(in_ready), 32'd1);
        applyIndex(1'b1, 9, 1'b0, 1'b0);
        step();
        checkOutput("full_pair5_count", 32'(count), 32'd4);
        checkOutput("full_pair5_half", 32'(half_pending), 32'd0);
        applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 5'h0, 1'b0, 1'b1);
        for (int p = 1; p <= 4; p++) begin
            checkOutput($sformatf("drain%0d_instr1", p), new_instr1_in, word_of(2 * p));
            checkOutput($sformatf("drain%0d_instr2", p), new_instr2_in, word_of(2 * p + 1));
            step();
        end
        checkOutput("drain_empty", 32'(count), 32'd0);

        // Steady state at count=2 with simultaneous push/pop across wrap
        applyIndex(1'b1, 20, 1'b1, 1'b0);
        step();
        applyIndex(1'b1, 21, 1'b1, 1'b0);
        step();
        checkOutput("steady_fill", 32'(count), 32'd2);
        for (int j = 0; j < 6; j++) begin
            applyIndex(1'b1, 22 + j, 1'b1, 1'b1);
            checkOutput($sformatf("steady%0d_instr1", j), new_instr1_in, word_of(20 + j));
            checkOutput($sformatf("steady%0d_instr2", j), new_instr2_in, 32'h0);
            step();
            checkOutput($sformatf("steady%0d_count", j), 32'(count), 32'd2);
        end
        applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 5'h0, 1'b0, 1'b1);
        checkOutput("steady_tail1", new_instr1_in, word_of(26));
        step();
        checkOutput("steady_tail2", new_instr1_in, word_of(27));
        step();
        checkOutput("steady_drained", 32'(count), 32'd0);

        // Reset discards buffered pairs and the staged half
        for (int i = 30; i < 37; i++) begin
            applyIndex(1'b1, i, 1'b0, 1'b0);
            step();
        end
        checkOutput("prerst_count", 32'(count), 32'd3);
        checkOutput("prerst_half", 32'(half_pending), 32'd1);
        applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 5'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checkOutput("midrst_count", 32'(count), 32'd0);
        checkOutput("midrst_half", 32'(half_pending), 32'd0);
        checkOutput("midrst_pair_valid", 32'(pair_valid), 32'd0);
        checkOutput("midrst_instr1", new_instr1_in, 32'h0);
        applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 5'h0, 1'b1, 1'b1);
        step();
        checkOutput("postrst_flush_count", 32'(count), 32'd0);
        checkOutput("postrst_instr1", new_instr1_in, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
